// File: rtl/montgomery_reduce_scheduler.sv
// montgomery_reduce_scheduler
// Shares one Montgomery reduction datapath between two requesters, one job at
// a time. A round-robin grant picks the requester, its T blocks are forwarded
// to the reducer, the k/N constant block indices are tracked, and reducer
// output blocks are returned tagged with the owning requester. Constant
// consumption is audited at the end of every job.
module montgomery_reduce_scheduler #(
    parameter int REGISTER_SIZE = 32,
    parameter int NUM_BLOCKS    = 256,
    parameter int CONST_BLOCKS  = 128,
    parameter int K_PASSES      = 1,
    parameter int N_PASSES      = 3
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            req0_valid_in,
    input  logic [REGISTER_SIZE-1:0]        req0_block_in,
    output logic                            req0_ready_out,
    input  logic                            req1_valid_in,
    input  logic [REGISTER_SIZE-1:0]        req1_block_in,
    output logic                            req1_ready_out,
    output logic                            red_rst_out,
    output logic                            red_valid_out,
    output logic [REGISTER_SIZE-1:0]        red_T_block_out,
    input  logic                            red_consumed_k_in,
    input  logic                            red_consumed_N_in,
    input  logic                            red_valid_in,
    input  logic [REGISTER_SIZE-1:0]        red_data_block_in,
    output logic [$clog2(CONST_BLOCKS)-1:0] k_addr_out,
    output logic [$clog2(CONST_BLOCKS)-1:0] n_addr_out,
    output logic                            res_valid_out,
    output logic [REGISTER_SIZE-1:0]        res_block_out,
    output logic                            res_tag_out,
    output logic                            res_last_out,
    output logic                            busy_out,
    output logic                            err_out
);

    localparam int OUT_BLOCKS = NUM_BLOCKS / 2;
    localparam int ADDR_W     = $clog2(CONST_BLOCKS);
    localparam int BEAT_W     = $clog2(NUM_BLOCKS + 1);
    localparam int OUT_W      = $clog2(OUT_BLOCKS + 1);
    localparam int K_EXP      = K_PASSES * CONST_BLOCKS;
    localparam int N_EXP      = N_PASSES * CONST_BLOCKS;
    localparam int MAX_EXP    = (K_EXP > N_EXP) ? K_EXP : N_EXP;
    // One spare bit so a saturated counter can never alias an expected count.
    localparam int CNT_W      = $clog2(MAX_EXP + 1) + 1;

    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BLOCKS - 1);
    localparam logic [OUT_W-1:0]  OUT_ONE   = OUT_W'(1);
    localparam logic [OUT_W-1:0]  LAST_OUT  = OUT_W'(OUT_BLOCKS - 1);
    localparam logic [OUT_W-1:0]  OUT_DONE  = OUT_W'(OUT_BLOCKS);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CONST_BLOCKS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  K_EXP_C   = CNT_W'(K_EXP);
    localparam logic [CNT_W-1:0]  N_EXP_C   = CNT_W'(N_EXP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

    // Constant block index: wraps after the last block of the constant.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        if (a == LAST_ADDR) begin
            addr_inc = '0;
        end else begin
            addr_inc = a + ADDR_ONE;
        end
    endfunction

    // Consumption count: saturates so a runaway reducer still reads as wrong.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        if (c == CNT_MAX) begin
            cnt_inc = c;
        end else begin
            cnt_inc = c + CNT_ONE;
        end
    endfunction

    state_t                   state_r;
    state_t                   state_next_s;
    logic                     grant_r;
    logic                     grant_next_s;
    logic                     last_grant_r;
    logic                     last_grant_next_s;
    logic [BEAT_W-1:0]        beat_cnt_r;
    logic [OUT_W-1:0]         out_cnt_r;
    logic [ADDR_W-1:0]        k_addr_r;
    logic [ADDR_W-1:0]        n_addr_r;
    logic [ADDR_W-1:0]        k_addr_next_s;
    logic [ADDR_W-1:0]        n_addr_next_s;
    logic [CNT_W-1:0]         k_cnt_r;
    logic [CNT_W-1:0]         n_cnt_r;
    logic [CNT_W-1:0]         k_cnt_next_s;
    logic [CNT_W-1:0]         n_cnt_next_s;
    logic [1:0]               red_rst_pipe_r;
    logic                     red_valid_r;
    logic [REGISTER_SIZE-1:0] red_T_block_r;
    logic                     res_valid_r;
    logic [REGISTER_SIZE-1:0] res_block_r;
    logic                     res_tag_r;
    logic                     res_last_r;
    logic                     busy_r;
    logic                     err_r;

    logic                     load_beat_s;
    logic                     drain_beat_s;
    logic                     last_out_s;
    logic                     stray_s;
    logic                     collision_s;
    logic                     miscount_s;
    logic                     err_next_s;
    logic [REGISTER_SIZE-1:0] beat_data_s;

    // Ready is a pure decode of the registered state and grant.
    assign req0_ready_out = (state_r == ST_LOAD) && (grant_r == 1'b0);
    assign req1_ready_out = (state_r == ST_LOAD) && (grant_r == 1'b1);

    assign red_rst_out     = red_rst_pipe_r[1];
    assign red_valid_out   = red_valid_r;
    assign red_T_block_out = red_T_block_r;
    assign k_addr_out      = k_addr_r;
    assign n_addr_out      = n_addr_r;
    assign res_valid_out   = res_valid_r;
    assign res_block_out   = res_block_r;
    assign res_tag_out     = res_tag_r;
    assign res_last_out    = res_last_r;
    assign busy_out        = busy_r;
    assign err_out         = err_r;

    // Next-state, arbitration and beat qualification for the job FSM.
    always_comb begin
        state_next_s      = state_r;
        grant_next_s      = grant_r;
        last_grant_next_s = last_grant_r;
        load_beat_s       = 1'b0;
        drain_beat_s      = 1'b0;
        stray_s           = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stray_s = red_valid_in;
                if (req0_valid_in || req1_valid_in) begin
                    if (req0_valid_in && req1_valid_in) begin
                        grant_next_s = ~last_grant_r;
                    end else begin
                        grant_next_s = req1_valid_in;
                    end
                    last_grant_next_s = grant_next_s;
                    state_next_s      = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                stray_s = red_valid_in;
                if (grant_r) begin
                    load_beat_s = req1_valid_in;
                end else begin
                    load_beat_s = req0_valid_in;
                end
                if (load_beat_s && (beat_cnt_r == LAST_BEAT)) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                // One extra DRAIN cycle after the last result keeps busy high
                // alongside res_last_out; anything arriving then is stray.
                if (out_cnt_r == OUT_DONE) begin
                    stray_s      = red_valid_in;
                    state_next_s = ST_IDLE;
                end else begin
                    drain_beat_s = red_valid_in;
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                stray_s      = red_valid_in;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Data of the granted requester.
    always_comb begin
        beat_data_s = '0;
        if (grant_r) begin
            beat_data_s = req1_block_in;
        end else begin
            beat_data_s = req0_block_in;
        end
    end

    // Constant address and consumption counters; parked at zero while idle.
    always_comb begin
        k_addr_next_s = k_addr_r;
        n_addr_next_s = n_addr_r;
        k_cnt_next_s  = k_cnt_r;
        n_cnt_next_s  = n_cnt_r;
        if (state_r == ST_IDLE) begin
            k_addr_next_s = '0;
            n_addr_next_s = '0;
            k_cnt_next_s  = '0;
            n_cnt_next_s  = '0;
        end else begin
            if (red_consumed_k_in) begin
                k_addr_next_s = addr_inc(k_addr_r);
                k_cnt_next_s  = cnt_inc(k_cnt_r);
            end else begin
                k_addr_next_s = k_addr_r;
                k_cnt_next_s  = k_cnt_r;
            end
            if (red_consumed_N_in) begin
                n_addr_next_s = addr_inc(n_addr_r);
                n_cnt_next_s  = cnt_inc(n_cnt_r);
            end else begin
                n_addr_next_s = n_addr_r;
                n_cnt_next_s  = n_cnt_r;
            end
        end
    end

    // Error sources: stray reducer output, collision with a load beat, and a
    // wrong constant-consumption total on the final result beat.
    always_comb begin
        last_out_s  = drain_beat_s && (out_cnt_r == LAST_OUT);
        collision_s = load_beat_s && red_valid_in;
        if (last_out_s) begin
            miscount_s = (k_cnt_next_s != K_EXP_C) || (n_cnt_next_s != N_EXP_C);
        end else begin
            miscount_s = 1'b0;
        end
        err_next_s = err_r | stray_s | collision_s | miscount_s;
    end

    // Reducer reset: asserted with rst_in, released on the 2nd clock edge.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            red_rst_pipe_r <= 2'b11;
        end else begin
            red_rst_pipe_r <= {red_rst_pipe_r[0], 1'b0};
        end
    end

    // FSM state, grant history and job beat counters.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r      <= ST_IDLE;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            beat_cnt_r   <= '0;
            out_cnt_r    <= '0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            grant_r      <= grant_next_s;
            last_grant_r <= last_grant_next_s;
            busy_r       <= (state_next_s != ST_IDLE);
            if (state_r == ST_IDLE) begin
                beat_cnt_r <= '0;
                out_cnt_r  <= '0;
            end else begin
                if (load_beat_s) begin
                    beat_cnt_r <= beat_cnt_r + BEAT_ONE;
                end
                if (drain_beat_s) begin
                    out_cnt_r <= out_cnt_r + OUT_ONE;
                end
            end
        end
    end

    // Constant address and count registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            k_addr_r <= '0;
            n_addr_r <= '0;
            k_cnt_r  <= '0;
            n_cnt_r  <= '0;
        end else begin
            k_addr_r <= k_addr_next_s;
            n_addr_r <= n_addr_next_s;
            k_cnt_r  <= k_cnt_next_s;
            n_cnt_r  <= n_cnt_next_s;
        end
    end

    // Forward accepted T blocks to the reducer one cycle after the handshake.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            red_valid_r   <= 1'b0;
            red_T_block_r <= '0;
        end else begin
            red_valid_r <= load_beat_s;
            if (load_beat_s) begin
                red_T_block_r <= beat_data_s;
            end
        end
    end

    // Return reducer output blocks tagged with the owning requester.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            res_valid_r <= 1'b0;
            res_block_r <= '0;
            res_tag_r   <= 1'b0;
            res_last_r  <= 1'b0;
        end else begin
            res_valid_r <= drain_beat_s;
            res_last_r  <= last_out_s;
            if (drain_beat_s) begin
                res_block_r <= red_data_block_in;
                res_tag_r   <= grant_r;
            end
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_next_s;
        end
    end

endmodule

// File: tb/tb_montgomery_reduce_scheduler.sv
// Directed testbench for montgomery_reduce_scheduler with a small job size
// (8 T blocks, 4-block constants) and a task-driven reducer model.
module tb_montgomery_reduce_scheduler;

    localparam int RS = 32;
    localparam int NB = 8;
    localparam int CB = 4;
    localparam int OB = NB / 2;
    localparam int AW = 2;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          req0_valid_in, req1_valid_in;
    logic [RS-1:0] req0_block_in, req1_block_in;
    logic          req0_ready_out, req1_ready_out;
    logic          red_rst_out, red_valid_out;
    logic [RS-1:0] red_T_block_out;
    logic          red_consumed_k_in, red_consumed_N_in, red_valid_in;
    logic [RS-1:0] red_data_block_in;
    logic [AW-1:0] k_addr_out, n_addr_out;
    logic          res_valid_out, res_tag_out, res_last_out;
    logic [RS-1:0] res_block_out;
    logic          busy_out, err_out;

    int checks = 0;
    int errors = 0;

    logic          cap_valid [0:OB-1];
    logic [RS-1:0] cap_block [0:OB-1];
    logic          cap_tag   [0:OB-1];
    logic          cap_last  [0:OB-1];
    logic          cap_err   [0:OB-1];
    logic          cap_busy  [0:OB-1];
    logic          cap_busy_after;
    logic          cap_valid_after;

    montgomery_reduce_scheduler #(
        .REGISTER_SIZE(RS),
        .NUM_BLOCKS   (NB),
        .CONST_BLOCKS (CB),
        .K_PASSES     (1),
        .N_PASSES     (3)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .req0_valid_in    (req0_valid_in),
        .req0_block_in    (req0_block_in),
        .req0_ready_out   (req0_ready_out),
        .req1_valid_in    (req1_valid_in),
        .req1_block_in    (req1_block_in),
        .req1_ready_out   (req1_ready_out),
        .red_rst_out      (red_rst_out),
        .red_valid_out    (red_valid_out),
        .red_T_block_out  (red_T_block_out),
        .red_consumed_k_in(red_consumed_k_in),
        .red_consumed_N_in(red_consumed_N_in),
        .red_valid_in     (red_valid_in),
        .red_data_block_in(red_data_block_in),
        .k_addr_out       (k_addr_out),
        .n_addr_out       (n_addr_out),
        .res_valid_out    (res_valid_out),
        .res_block_out    (res_block_out),
        .res_tag_out      (res_tag_out),
        .res_last_out     (res_last_out),
        .busy_out         (busy_out),
        .err_out          (err_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic clear_inputs();
        req0_valid_in = 1'b0; req0_block_in = '0;
        req1_valid_in = 1'b0; req1_block_in = '0;
        red_consumed_k_in = 1'b0; red_consumed_N_in = 1'b0;
        red_valid_in = 1'b0; red_data_block_in = '0;
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
    endtask

    task automatic set_req(input bit req, input logic v, input logic [RS-1:0] blk);
        if (req) begin
            req1_valid_in = v; req1_block_in = blk;
        end else begin
            req0_valid_in = v; req0_block_in = blk;
        end
    endtask

    // Streams NB beats base, base+1, ... from one requester, waiting on ready.
    task automatic send_job(input bit req, input logic [RS-1:0] base,
                            output bit ok, output bit other_ready);
        int  i = 0;
        int  guard = 0;
        bit  hs;
        other_ready = 1'b0;
        set_req(req, 1'b1, base);
        while (i < NB && guard < 100) begin
            hs = req ? req1_ready_out : req0_ready_out;
            if (req ? req0_ready_out : req1_ready_out) other_ready = 1'b1;
            @(negedge clk_in);
            guard++;
            if (hs) begin
                i++;
                set_req(req, (i < NB), base + i);
            end
        end
        ok = (i == NB);
        if (!ok) set_req(req, 1'b0, '0);
    endtask

    task automatic reducer_consts(input int nk, input int nn);
        for (int c = 0; c < ((nk > nn) ? nk : nn); c++) begin
            red_consumed_k_in = (c < nk);
            red_consumed_N_in = (c < nn);
            @(negedge clk_in);
        end
        red_consumed_k_in = 1'b0;
        red_consumed_N_in = 1'b0;
    endtask

    task automatic reducer_outputs(input logic [RS-1:0] obase);
        for (int o = 0; o < OB; o++) begin
            red_valid_in = 1'b1;
            red_data_block_in = obase + o;
            @(negedge clk_in);
            cap_valid[o] = res_valid_out;
            cap_block[o] = res_block_out;
            cap_tag[o]   = res_tag_out;
            cap_last[o]  = res_last_out;
            cap_err[o]   = err_out;
            cap_busy[o]  = busy_out;
        end
        red_valid_in = 1'b0;
        red_data_block_in = '0;
        @(negedge clk_in);
        cap_busy_after  = busy_out;
        cap_valid_after = res_valid_out;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        clear_inputs();
        @(negedge clk_in);
        checks++;
        if ({red_rst_out, busy_out, err_out, red_valid_out, res_valid_out,
             res_tag_out, res_last_out, req0_ready_out, req1_ready_out} !== 9'b100000000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 100000000",
                     {red_rst_out, busy_out, err_out, red_valid_out, res_valid_out,
                      res_tag_out, res_last_out, req0_ready_out, req1_ready_out});
        end
        checks++;
        if ({k_addr_out, n_addr_out, red_T_block_out, res_block_out} !== '0) begin
            errors++;
            $display("FAIL reset_data: got k=%0h n=%0h t=%0h r=%0h expected all 0",
                     k_addr_out, n_addr_out, red_T_block_out, res_block_out);
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if (red_rst_out !== 1'b1) begin
            errors++;
            $display("FAIL red_rst_edge1: got %b expected 1", red_rst_out);
        end
        @(negedge clk_in);
        checks++;
        if (red_rst_out !== 1'b0) begin
            errors++;
            $display("FAIL red_rst_edge2: got %b expected 0", red_rst_out);
        end
    endtask

    task automatic test_single_job();
        int i = 0;
        int guard = 0;
        bit v, hs;
        logic [RS-1:0] exp_blk;
        do_reset();
        req0_valid_in = 1'b1;
        req0_block_in = 32'h1;
        while (i < NB && guard < 100) begin
            v = req0_valid_in;
            hs = v && req0_ready_out;
            exp_blk = req0_block_in;
            @(negedge clk_in);
            guard++;
            checks++;
            if (hs) begin
                if (red_valid_out !== 1'b1 || red_T_block_out !== exp_blk) begin
                    errors++;
                    $display("FAIL fwd_beat: got v=%b blk=%0h expected v=1 blk=%0h",
                             red_valid_out, red_T_block_out, exp_blk);
                end
                i++;
                req0_block_in = i + 1;
                req0_valid_in = (i == 3) ? 1'b0 : (i < NB);
            end else begin
                if (red_valid_out !== 1'b0) begin
                    errors++;
                    $display("FAIL fwd_idle: got v=%b expected 0", red_valid_out);
                end
                if (!v) req0_valid_in = 1'b1;
            end
        end
        checks++;
        if (i != NB) begin
            errors++;
            $display("FAIL load_timeout: got %0d beats expected %0d", i, NB);
        end
        reducer_consts(4, 12);
        reducer_outputs(32'hA0);
        for (int o = 0; o < OB; o++) begin
            checks++;
            if (cap_valid[o] !== 1'b1 || cap_block[o] !== (32'hA0 + o) || cap_tag[o] !== 1'b0
                || cap_last[o] !== (o == OB - 1) || cap_err[o] !== 1'b0) begin
                errors++;
                $display("FAIL single_res%0d: got v=%b blk=%0h tag=%b last=%b err=%b expected v=1 blk=%0h tag=0 last=%b err=0",
                         o, cap_valid[o], cap_block[o], cap_tag[o], cap_last[o], cap_err[o],
                         32'hA0 + o, (o == OB - 1));
            end
        end
        checks++;
        if (cap_busy[OB-1] !== 1'b1 || cap_busy_after !== 1'b0 || cap_valid_after !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: got last=%b after=%b valid_after=%b expected 1 0 0",
                     cap_busy[OB-1], cap_busy_after, cap_valid_after);
        end
    endtask

    task automatic test_tie();
        bit ok, oth;
        do_reset();
        req1_valid_in = 1'b1;
        req1_block_in = 32'h5555_0000;
        send_job(1'b0, 32'h10, ok, oth);
        checks++;
        if (ok !== 1'b1 || oth !== 1'b0) begin
            errors++;
            $display("FAIL tie1_grant: got ok=%b other_ready=%b expected 1 0", ok, oth);
        end
        reducer_consts(4, 12);
        reducer_outputs(32'hB0);
        checks++;
        if ({cap_tag[0], cap_tag[1], cap_tag[2], cap_tag[3], cap_last[3]} !== 5'b00001) begin
            errors++;
            $display("FAIL tie1_tags: got %b expected 00001",
                     {cap_tag[0], cap_tag[1], cap_tag[2], cap_tag[3], cap_last[3]});
        end
        send_job(1'b1, 32'h20, ok, oth);
        checks++;
        if (ok !== 1'b1 || oth !== 1'b0) begin
            errors++;
            $display("FAIL tie2_grant: got ok=%b other_ready=%b expected 1 0", ok, oth);
        end
        reducer_consts(4, 12);
        reducer_outputs(32'hC0);
        checks++;
        if ({cap_tag[0], cap_tag[1], cap_tag[2], cap_tag[3], cap_last[3], cap_err[3]} !== 6'b111110) begin
            errors++;
            $display("FAIL tie2_tags: got %b expected 111110",
                     {cap_tag[0], cap_tag[1], cap_tag[2], cap_tag[3], cap_last[3], cap_err[3]});
        end
        req0_valid_in = 1'b1;
        req1_valid_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if (req0_ready_out !== 1'b1 || req1_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL tie3_grant: got r0=%b r1=%b expected 1 0", req0_ready_out, req1_ready_out);
        end
        clear_inputs();
    endtask

    task automatic test_addr_wrap();
        bit ok, oth;
        logic [AW-1:0] exp_n, exp_k;
        do_reset();
        send_job(1'b0, 32'h30, ok, oth);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL wrap_load: got ok=%b expected 1", ok);
        end
        for (int j = 1; j <= 12; j++) begin
            red_consumed_N_in = 1'b1;
            red_consumed_k_in = (j <= 4);
            @(negedge clk_in);
            exp_n = AW'(j % 4);
            exp_k = (j <= 4) ? AW'(j % 4) : 2'd0;
            checks++;
            if (n_addr_out !== exp_n || k_addr_out !== exp_k) begin
                errors++;
                $display("FAIL wrap_addr%0d: got n=%0d k=%0d expected n=%0d k=%0d",
                         j, n_addr_out, k_addr_out, exp_n, exp_k);
            end
        end
        red_consumed_N_in = 1'b0;
        red_consumed_k_in = 1'b0;
        reducer_outputs(32'hD0);
        checks++;
        if (cap_last[OB-1] !== 1'b1 || cap_err[OB-1] !== 1'b0 || err_out !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end: got last=%b err=%b/%b expected 1 0 0",
                     cap_last[OB-1], cap_err[OB-1], err_out);
        end
    endtask

    task automatic test_miscount();
        bit ok, oth;
        do_reset();
        send_job(1'b0, 32'h40, ok, oth);
        reducer_consts(4, 11);
        reducer_outputs(32'hE0);
        checks++;
        if (ok !== 1'b1 || cap_err[OB-2] !== 1'b0) begin
            errors++;
            $display("FAIL miscount_early: got ok=%b err=%b expected 1 0", ok, cap_err[OB-2]);
        end
        checks++;
        if (cap_err[OB-1] !== 1'b1 || cap_last[OB-1] !== 1'b1) begin
            errors++;
            $display("FAIL miscount_flag: got err=%b last=%b expected 1 1",
                     cap_err[OB-1], cap_last[OB-1]);
        end
        repeat (5) @(negedge clk_in);
        checks++;
        if (err_out !== 1'b1) begin
            errors++;
            $display("FAIL miscount_sticky: got %b expected 1", err_out);
        end
        do_reset();
        checks++;
        if (err_out !== 1'b0) begin
            errors++;
            $display("FAIL miscount_clear: got %b expected 0", err_out);
        end
    endtask

    task automatic test_stray();
        do_reset();
        req0_valid_in = 1'b1;
        req0_block_in = 32'h40;
        @(negedge clk_in);
        checks++;
        if (req0_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL stray_grant: got %b expected 1", req0_ready_out);
        end
        red_valid_in = 1'b1;
        red_data_block_in = 32'h99;
        @(negedge clk_in);
        checks++;
        if (err_out !== 1'b1 || res_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL stray_err: got err=%b res_valid=%b expected 1 0", err_out, res_valid_out);
        end
        red_valid_in = 1'b0;
        req0_valid_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if (err_out !== 1'b1 || res_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL stray_hold: got err=%b res_valid=%b expected 1 0", err_out, res_valid_out);
        end
    endtask

    task automatic test_reset_mid_load();
        int i = 0;
        int guard = 0;
        bit hs, ok, oth;
        do_reset();
        req0_valid_in = 1'b1;
        req0_block_in = 32'h1;
        while (i < 3 && guard < 50) begin
            hs = req0_ready_out;
            @(negedge clk_in);
            guard++;
            if (hs) begin
                i++;
                req0_block_in = i + 1;
            end
        end
        req0_valid_in = 1'b0;
        red_consumed_k_in = 1'b1;
        @(negedge clk_in);
        red_consumed_k_in = 1'b0;
        checks++;
        if (k_addr_out !== 2'd1 || busy_out !== 1'b1 || i != 3) begin
            errors++;
            $display("FAIL midload_pre: got k=%0d busy=%b beats=%0d expected 1 1 3",
                     k_addr_out, busy_out, i);
        end
        #2 rst_in = 1'b0;
        #1;
        checks++;
        if ({red_rst_out, busy_out, red_valid_out, req0_ready_out, err_out} !== 5'b10000
            || k_addr_out !== 2'd0) begin
            errors++;
            $display("FAIL midload_async: got %b k=%0d expected 10000 k=0",
                     {red_rst_out, busy_out, red_valid_out, req0_ready_out, err_out}, k_addr_out);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if (red_rst_out !== 1'b1) begin
            errors++;
            $display("FAIL midload_rst1: got %b expected 1", red_rst_out);
        end
        @(negedge clk_in);
        checks++;
        if (red_rst_out !== 1'b0) begin
            errors++;
            $display("FAIL midload_rst2: got %b expected 0", red_rst_out);
        end
        send_job(1'b0, 32'h50, ok, oth);
        reducer_consts(4, 12);
        reducer_outputs(32'hF0);
        checks++;
        if (ok !== 1'b1 || cap_last[OB-1] !== 1'b1 || cap_err[OB-1] !== 1'b0
            || cap_block[0] !== 32'hF0 || cap_tag[0] !== 1'b0) begin
            errors++;
            $display("FAIL midload_resubmit: got ok=%b last=%b err=%b blk=%0h tag=%b expected 1 1 0 f0 0",
                     ok, cap_last[OB-1], cap_err[OB-1], cap_block[0], cap_tag[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_tie();
        test_addr_wrap();
        test_miscount();
        test_stray();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/montgomery_reduce_scheduler.md
# montgomery_reduce_scheduler

Job-level controller that shares one Montgomery reduction datapath between two requesters. It grants one requester per job using round-robin arbitration and forwards that requester's T blocks into the reducer. It also owns the block-index counters for the k and N constant memories, routes the reducer's output blocks back with a requester tag, and checks each job's constant-consumption counts. Only one job is in flight at a time.

## Interface
Parameters:
- REGISTER_SIZE, 32, bits per block
- NUM_BLOCKS, 256, T blocks per job; output job length is OUT_BLOCKS = NUM_BLOCKS/2
- CONST_BLOCKS, 128, blocks per k or N constant (R/REGISTER_SIZE)
- K_PASSES, 1, expected full passes over k per job
- N_PASSES, 3, expected full passes over N per job (multiply, compare, subtract)

Ports:
- clk_in, input, 1, clock
- rst_in, input, 1, reset; one clock, reset is asynchronous and active-low
- req0_valid_in / req1_valid_in, input, 1, requester has a T block
- req0_block_in / req1_block_in, input, REGISTER_SIZE, T block, least significant first
- req0_ready_out / req1_ready_out, output, 1, beat accepted when valid && ready
- red_rst_out, output, 1, active-high reset for the reducer
- red_valid_out, output, 1, T block valid to reducer
- red_T_block_out, output, REGISTER_SIZE, T block to reducer
- red_consumed_k_in, input, 1, reducer took current k block
- red_consumed_N_in, input, 1, reducer took current N block
- red_valid_in, input, 1, reducer output block valid
- red_data_block_in, input, REGISTER_SIZE, reducer output block
- k_addr_out, output, $clog2(CONST_BLOCKS), index of k block to present
- n_addr_out, output, $clog2(CONST_BLOCKS), index of N block to present
- res_valid_out, output, 1, result block valid
- res_block_out, output, REGISTER_SIZE, result block
- res_tag_out, output, 1, requester that owns the result
- res_last_out, output, 1, final result block of the job
- busy_out, output, 1, state != IDLE
- err_out, output, 1, sticky protocol/consumption error

## Operation
- FSM states are IDLE, LOAD and DRAIN.
- **IDLE**
  - The k and N address and consumption counters are held at 0.
  - If any reqN_valid_in is high, grant one requester: if both are high, grant the one not in last_grant.
  - On a grant, record grant and last_grant, then go to LOAD.
- **LOAD**
  - reqN_ready_out = (state == LOAD && grant == N), combinational. The other requester's ready stays 0.
  - Each handshake is forwarded to the reducer and increments beat_cnt.
  - Gaps between beats are allowed.
  - After NUM_BLOCKS beats, go to DRAIN.
- **DRAIN**
  - Each red_valid_in produces one result beat tagged with grant.
  - After OUT_BLOCKS beats, return to IDLE.
- **Constant counters**
  - In any state other than IDLE, red_consumed_k_in increments k_addr_out, wrapping from CONST_BLOCKS-1 to 0; k_cnt counts total pulses.
  - n_addr_out and n_cnt behave the same way for red_consumed_N_in.
  - k and N pulses in the same cycle are both counted.
- **End-of-job check**: on the last result beat, raise err_out if k_cnt != K_PASSES*CONST_BLOCKS or n_cnt != N_PASSES*CONST_BLOCKS.
- **Other errors**: err_out is also raised by:
  - red_valid_in outside DRAIN (the beat is dropped, not forwarded);
  - red_valid_in in the same cycle as a LOAD beat.
- err_out clears only on reset.
- **Reset**
  - Asserting rst_in low at any point aborts the job. All state returns to IDLE with last_grant = 1, so requester 0 wins the first tie.
  - The requester must resubmit the whole job.

## Timing
- Reset values:
  - all outputs 0 except red_rst_out = 1;
  - k_addr_out and n_addr_out = 0;
  - state IDLE.
- red_rst_out is asserted asynchronously with rst_in low and deasserts synchronously on the 2nd clk_in rising edge after rst_in rises.
- The grant takes 1 cycle: with a valid seen in IDLE at edge t, ready is high in the cycle following edge t.
- red_valid_out and red_T_block_out are registered and appear 1 cycle after the handshake. red_valid_out is never high outside a beat.
- k_addr_out and n_addr_out are registered. An address advances the cycle after its consumed pulse. The constant memory must present data for the current address combinationally.
- Result path: res_valid_out, res_block_out, res_tag_out and res_last_out are registered, 1 cycle after red_valid_in.
- busy_out drops in the cycle after res_last_out.
- The next grant can occur in the same cycle busy_out is low.
- There is no backpressure on the result port: the consumer must accept every beat.

## Test plan
Directed scenarios use NUM_BLOCKS=8, CONST_BLOCKS=4 and a behavioural reducer model that issues 4 k pulses, 12 N pulses and then 4 outputs.
- **Single job, requester 0**: req0 streams 8 blocks 0x1..0x8 → red_T_block_out carries the same sequence, 1-cycle delayed; 4 results with tag 0; res_last_out on the 4th; err_out=0; busy_out=0 the next cycle.
- **Tie**: both valid from reset → req0 is granted; its job completes; req1 is granted next; a third tie grants req0.
- **Address wrap**: 12 N pulses → n_addr_out goes 0,1,2,3,0,…,3,0; at job end n_cnt=12 and no error.
- **Miscount**: model issues only 11 N pulses → err_out rises with res_last_out and stays high until reset.
- **Stray output**: red_valid_in pulsed during LOAD → err_out=1; no res_valid_out pulse.
- **Reset mid-LOAD**: rst_in low after 3 beats → outputs reset immediately and red_rst_out=1; after release, red_rst_out falls at the 2nd edge; a resubmitted job completes with err_out=0.
